// File: rtl/byte_serial_adder.sv
// Multi-cycle add/subtract unit: one SLICE-bit ripple slice per clock, LSB slice first,
// carry registered between slices, valid/ready handshake on both sides.
//
// state  | meaning
// IDLE   | waiting for an operation, in_ready high
// ADD    | processing slice idx_q, one slice per clock
// DONE   | result held, out_valid high until out_ready

module byte_serial_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             next_state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_out_q;
    logic               overflow_q;

    logic               accept;
    logic               last_slice;
    logic [SLICE-1:0]   a_slice;
    logic [SLICE-1:0]   b_slice;
    logic [SLICE:0]     slice_sum;

    assign accept     = in_valid && in_ready;
    assign last_slice = (idx_q == LAST_IDX);

    always_comb begin
        a_slice   = a_q[idx_q*SLICE +: SLICE];
        b_slice   = b_q[idx_q*SLICE +: SLICE];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE: if (accept)     next_state = S_ADD;
            S_ADD:  if (last_slice) next_state = S_DONE;
            S_DONE: if (out_ready)  next_state = S_IDLE;
            default:                next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_ADD) || (state_q == S_DONE);
    end

    // Subtract is folded in at accept: B is inverted and the carry seeded with 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= operand_a;
            b_q     <= operand_b ^ {WIDTH{sub}};
            carry_q <= sub;
            idx_q   <= '0;
        end else if (state_q == S_ADD) begin
            result_q[idx_q*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
            carry_q <= slice_sum[SLICE];
            if (last_slice) begin
                idx_q       <= '0;
                carry_out_q <= slice_sum[SLICE];
                overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                               (slice_sum[SLICE-1] != a_q[WIDTH-1]);
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Randomized bench for byte_serial_adder against an integer-arithmetic reference model.

module tb_byte_serial_adder;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    byte_serial_adder #(.WIDTH(32), .SLICE(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on 64-bit values.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] r, output logic c, output logic v);
        longint ua, ub, sa, sb, ures, sres;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            ures = ua - ub;
            sres = sa - sb;
            c    = (ua >= ub);
        end else begin
            ures = ua + ub;
            sres = sa + sb;
            c    = (ures >= 64'sh1_0000_0000);
        end
        r = ures[31:0];
        v = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int hold);
        logic [31:0] exp_r;
        logic        exp_c, exp_v;
        model(a, b, s, exp_r, exp_c, exp_v);
        check_val("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        operand_a = a;
        operand_b = b;
        sub       = s;
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_val("out_valid_add", 32'(out_valid), 32'd0);
            check_val("in_ready_add", 32'(in_ready), 32'd0);
            check_val("busy_add", 32'(busy), 32'd1);
            in_valid  = 1'($urandom_range(0, 1));
            operand_a = $urandom;
            operand_b = $urandom;
            sub       = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b0;
        check_val("out_valid_done", 32'(out_valid), 32'd1);
        check_val("result", result, exp_r);
        check_val("carry_out", 32'(carry_out), 32'(exp_c));
        check_val("overflow", 32'(overflow), 32'(exp_v));
        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'b1;
            operand_a = $urandom;
            operand_b = $urandom;
            tick();
            check_val("hold_out_valid", 32'(out_valid), 32'd1);
            check_val("hold_in_ready", 32'(in_ready), 32'd0);
            check_val("hold_result", result, exp_r);
            check_val("hold_flags", {30'd0, carry_out, overflow}, {30'd0, exp_c, exp_v});
        end
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("release_out_valid", 32'(out_valid), 32'd0);
        check_val("release_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        operand_a = '0;
        operand_b = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        #12;
        check_val("rst_result", result, 32'd0);
        check_val("rst_flags", {29'd0, out_valid, carry_out, overflow}, 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        tick();

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 2);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 3);

        // Abort mid-operation while slice 2 is being processed.
        in_valid  = 1'b1;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h0BAD_F00D;
        sub       = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_val("abort_result", result, 32'd0);
        check_val("abort_flags", {29'd0, out_valid, carry_out, overflow}, 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_in_ready", 32'(in_ready), 32'd1);
        #3;
        reset_n = 1'b1;
        tick();
        check_val("post_abort_out_valid", 32'(out_valid), 32'd0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case (t % 4)
                0: ra[31:24] = 8'h7F;
                1: rb = ~ra;
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
